// File: rtl/riscv_pkg.sv
// Shared types for the RISC-V trace sink: record layout, flag word and FSM states.
// Build option: RISCV_TRACE_MEM_EN adds mem_addr/mem_data as words W4/W5 of each record.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int IDX_W = 3;

`ifdef RISCV_TRACE_MEM_EN
  localparam int TRACE_WORDS = 6;
`else
  localparam int TRACE_WORDS = 4;
`endif

  typedef struct packed {
    logic       mem_wrt;
    logic       mem_read;
    logic       update;
    logic       halt;
    logic [4:0] reg_addr;
  } trace_flags_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    trace_flags_t    flags;
    logic [XLEN-1:0] reg_data;
`ifdef RISCV_TRACE_MEM_EN
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
`endif
  } trace_rec_t;

  typedef enum logic [1:0] {
    TR_IDLE = 2'd0,
    TR_SEND = 2'd1,
    TR_HALT = 2'd2
  } trace_state_e;

  // Expand the compact flag struct into the stream word layout:
  // [31]mem_wrt [30]mem_read [29]update [28]halt [4:0]reg_addr, rest zero.
  function automatic logic [XLEN-1:0] flags_word(input trace_flags_t f);
    return {f.mem_wrt, f.mem_read, f.update, f.halt, 23'd0, f.reg_addr};
  endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// Record FIFO for the trace sink: synchronous write, registered count,
// pointers wrap by natural rollover (DEPTH is a power of two).
module riscv_trace_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  trace_rec_t               wdata_i,
  output trace_rec_t               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer/count values from the accepted push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array: written only, never reset (contents are qualified by count).
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_trace_sink.sv
// Trace sink for a single-cycle RISC-V core: captures one record per retired
// instruction, serialises it as XLEN-bit words, tracks drops and halt.
// Build option: RISCV_TRACE_MEM_EN (6 words per record instead of 4).
//
// Stream handshake: a word transfers on a rising edge where trace_valid_o and
// trace_ready_i are both 1. Once trace_valid_o is high, trace_data_o and
// trace_last_o stay unchanged until that transfer; valid never depends on ready.
module riscv_trace_sink
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  input  logic             update_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  instr_i,
  input  logic [4:0]       reg_addr_i,
  input  logic [XLEN-1:0]  reg_data_i,
  input  logic [XLEN-1:0]  mem_addr_i,
  input  logic [XLEN-1:0]  mem_data_i,
  input  logic             mem_wrt_i,
  input  logic             mem_read_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [XLEN-1:0]  trace_data_o,
  output logic             trace_last_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             halted_o,
  output logic             done_o,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRACE_WORDS - 1);

  trace_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             halted_q, overflow_q;
  logic [CNT_W-1:0] drop_cnt_q;

  trace_rec_t       rec_in, rec_head;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             capture, push, drop, pop;
  logic             is_halt;
  logic [XLEN-1:0]  word;

`ifndef RISCV_TRACE_MEM_EN
  logic unused_mem;
  assign unused_mem = ^{mem_addr_i, mem_data_i};
`endif

  // Core is never stalled: a record is either stored or counted as dropped.
  assign is_halt = (instr_i == '0);
  assign capture = valid_i && !halted_q;
  assign push    = capture && !fifo_full;
  assign drop    = capture && fifo_full;

  // Assemble the record for the retiring instruction.
  always_comb begin
    rec_in                = '0;
    rec_in.pc             = pc_i;
    rec_in.instr          = instr_i;
    rec_in.flags.mem_wrt  = mem_wrt_i;
    rec_in.flags.mem_read = mem_read_i;
    rec_in.flags.update   = update_i;
    rec_in.flags.halt     = is_halt;
    rec_in.flags.reg_addr = reg_addr_i;
    rec_in.reg_data       = reg_data_i;
`ifdef RISCV_TRACE_MEM_EN
    if (mem_wrt_i || mem_read_i) begin
      rec_in.mem_addr = mem_addr_i;
      rec_in.mem_data = mem_data_i;
    end
`endif
  end

  riscv_trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rec_in),
    .rdata_o (rec_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Serialiser next state: walk the head record word by word, pop on its last word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      TR_IDLE: begin
        if (!fifo_empty)   state_d = TR_SEND;
        else if (halted_q) state_d = TR_HALT;
      end
      TR_SEND: begin
        if (trace_ready_i) begin
          if (idx_q == LAST_IDX) begin
            pop   = 1'b1;
            idx_d = '0;
            if ((fifo_count > CW'(1)) || push) state_d = TR_SEND;
            else if (halted_q)                 state_d = TR_HALT;
            else                               state_d = TR_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      TR_HALT: state_d = TR_HALT;
      default: state_d = TR_IDLE;
    endcase
  end

  // Select the current word of the head record; zero whenever not sending.
  always_comb begin
    word = '0;
    if (state_q == TR_SEND) begin
      case (idx_q)
        3'd0:    word = rec_head.pc;
        3'd1:    word = rec_head.instr;
        3'd2:    word = flags_word(rec_head.flags);
        3'd3:    word = rec_head.reg_data;
`ifdef RISCV_TRACE_MEM_EN
        3'd4:    word = rec_head.mem_addr;
        3'd5:    word = rec_head.mem_data;
`endif
        default: word = '0;
      endcase
    end
  end

  // FSM state and word index registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= TR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Halt, overflow and saturating drop counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (capture && is_halt) halted_q <= 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  assign trace_valid_o = (state_q == TR_SEND);
  assign trace_data_o  = word;
  assign trace_last_o  = (state_q == TR_SEND) && (idx_q == LAST_IDX);
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign halted_o      = halted_q;
  assign done_o        = (state_q == TR_HALT);
  assign dbg_state_o   = state_q;

endmodule
